// File: rtl/ssd_result_writer.sv
// AHB-Lite initiator writing classifier results (code, then done strobe) to the SSD responder.
// Optional readback verification of the code write is enabled by defining SSD_WR_READBACK_EN.
module ssd_result_writer #(
  parameter logic [31:0] SSD_BASE_ADDR  = 32'hC000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        result_valid_i,
  input  logic [4:0]  result_class_i,
  output logic        result_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [31:0] ahb_m0_haddr_o,
  output logic        ahb_m0_hwrite_o,
  output logic [2:0]  ahb_m0_hsize_o,
  output logic [2:0]  ahb_m0_hburst_o,
  output logic [3:0]  ahb_m0_hprot_o,
  output logic [1:0]  ahb_m0_htrans_o,
  output logic        ahb_m0_hmastlock_o,
  output logic [31:0] ahb_m0_hwdata_o,
  input  logic [31:0] ahb_m0_hrdata_i,
  input  logic        ahb_m0_hready_i,
  input  logic        ahb_m0_hresp_i
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_A_DATA, S_D_DATA, S_A_DONE, S_D_DONE
`ifdef SSD_WR_READBACK_EN
    , S_A_RB, S_D_RB
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic [4:0]  pend_cls_q, pend_cls_d;
  logic [4:0]  cur_cls_q, cur_cls_d;
  logic [7:0]  stall_q, stall_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        err_set, consume, is_dphase, is_active;
  logic        unused_rdata;

  assign unused_rdata = ^ahb_m0_hrdata_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pend_vld_q <= 1'b0;
      pend_cls_q <= 5'd0;
      cur_cls_q  <= 5'd0;
      stall_q    <= 8'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_cls_q <= pend_cls_d;
      cur_cls_q  <= cur_cls_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_cls_d = pend_cls_q;
    cur_cls_d  = cur_cls_q;
    done_d     = 1'b0;
    err_set    = 1'b0;
    consume    = 1'b0;
    is_active  = (state_q != S_IDLE);
    is_dphase  = (state_q == S_D_DATA) || (state_q == S_D_DONE)
`ifdef SSD_WR_READBACK_EN
                 || (state_q == S_D_RB)
`endif
                 ;

    if (result_valid_i && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_cls_d = result_class_i;
    end

    case (state_q)
      S_IDLE:   consume = pend_vld_q;
      S_A_DATA: if (ahb_m0_hready_i) state_d = S_D_DATA;
`ifdef SSD_WR_READBACK_EN
      S_D_DATA: if (ahb_m0_hready_i && !ahb_m0_hresp_i) state_d = S_A_RB;
      S_A_RB:   if (ahb_m0_hready_i) state_d = S_D_RB;
      S_D_RB: begin
        if (ahb_m0_hready_i && !ahb_m0_hresp_i) begin
          if (ahb_m0_hrdata_i[4:0] != cur_cls_q) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_A_DONE;
          end
        end
      end
`else
      S_D_DATA: if (ahb_m0_hready_i && !ahb_m0_hresp_i) state_d = S_A_DONE;
`endif
      S_A_DONE: if (ahb_m0_hready_i) state_d = S_D_DONE;
      S_D_DONE: begin
        // A waiting result chains straight into the next sequence with no idle gap.
        if (ahb_m0_hready_i && !ahb_m0_hresp_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          consume = pend_vld_q;
        end
      end
      default:  state_d = S_IDLE;
    endcase

    if (is_dphase && ahb_m0_hresp_i) begin
      err_set = 1'b1;
      state_d = S_IDLE;
    end
    if (is_active && !ahb_m0_hready_i && (stall_q == TMO)) begin
      err_set = 1'b1;
      state_d = S_IDLE;
    end

    if (consume) begin
      cur_cls_d  = pend_cls_q;
      pend_vld_d = 1'b0;
      state_d    = S_A_DATA;
    end

    if (state_d != state_q)                  stall_d = 8'd0;
    else if (is_active && !ahb_m0_hready_i)  stall_d = stall_q + 8'd1;
    else                                     stall_d = stall_q;

    err_d = err_clr_i ? 1'b0 : (err_q | err_set);
  end

  // Bus outputs decode purely from registered state.
  always_comb begin
    ahb_m0_haddr_o  = 32'd0;
    ahb_m0_hwrite_o = 1'b0;
    ahb_m0_htrans_o = 2'b00;
    ahb_m0_hwdata_o = 32'd0;
    case (state_q)
      S_A_DATA: begin
        ahb_m0_haddr_o  = SSD_BASE_ADDR;
        ahb_m0_hwrite_o = 1'b1;
        ahb_m0_htrans_o = 2'b10;
      end
      S_A_DONE: begin
        ahb_m0_haddr_o  = SSD_BASE_ADDR + 32'h4;
        ahb_m0_hwrite_o = 1'b1;
        ahb_m0_htrans_o = 2'b10;
      end
`ifdef SSD_WR_READBACK_EN
      S_A_RB: begin
        ahb_m0_haddr_o  = SSD_BASE_ADDR;
        ahb_m0_htrans_o = 2'b10;
      end
`endif
      S_D_DATA: ahb_m0_hwdata_o = {27'd0, cur_cls_q};
      S_D_DONE: ahb_m0_hwdata_o = 32'h1;
      default:  ;
    endcase
  end

  assign ahb_m0_hsize_o     = 3'b010;
  assign ahb_m0_hburst_o    = 3'b000;
  assign ahb_m0_hprot_o     = 4'b0011;
  assign ahb_m0_hmastlock_o = 1'b0;
  assign result_ready_o     = !pend_vld_q;
  assign busy_o             = (state_q != S_IDLE);
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_ssd_result_writer.sv
// Scoreboard bench for ssd_result_writer: a behavioural AHB responder/memory records completed
// transfers, which a monitor compares against the transfer list expected for each pushed result.
module tb_ssd_result_writer;
  localparam logic [31:0] BASE = 32'hC000_0000;
`ifdef SSD_WR_READBACK_EN
  localparam int LAT0 = 6;
  localparam int LAT1 = 9;
`else
  localparam int LAT0 = 4;
  localparam int LAT1 = 6;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        valid = 1'b0;
  logic [4:0]  cls = 5'd0;
  logic        ready, busy, done, err;
  logic        err_clr = 1'b0;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hmastlock;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  always #5 clk = ~clk;

  ssd_result_writer dut (
    .clk(clk), .resetn(resetn),
    .result_valid_i(valid), .result_class_i(cls), .result_ready_o(ready),
    .busy_o(busy), .done_o(done), .err_o(err), .err_clr_i(err_clr),
    .ahb_m0_haddr_o(haddr), .ahb_m0_hwrite_o(hwrite), .ahb_m0_hsize_o(hsize),
    .ahb_m0_hburst_o(hburst), .ahb_m0_hprot_o(hprot), .ahb_m0_htrans_o(htrans),
    .ahb_m0_hmastlock_o(hmastlock), .ahb_m0_hwdata_o(hwdata), .ahb_m0_hrdata_i(hrdata),
    .ahb_m0_hready_i(hready), .ahb_m0_hresp_i(hresp)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [64:0] exp_q[$];
  int exp_done = 0;
  int done_cnt = 0;
  int done_times[$];
  int cyc = 0, t_start = 0, last_lat = 0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Responder model state
  logic [31:0] mem = 32'd0;
  logic [31:0] rb_val = 32'd0;
  bit          rb_force = 1'b0;
  bit          dph = 1'b0, cap_write = 1'b0, err_arm = 1'b0, resp_pend = 1'b0, stall_arm = 1'b0;
  logic [31:0] cap_addr = 32'd0;
  int          ws = 0, wleft = 0, stall_left = 0;
  logic        hready_n = 1'b1, hresp_n = 1'b0;

  assign hrdata = rb_force ? rb_val : mem;

  always @(posedge clk) begin
    hready <= hready_n;
    hresp  <= hresp_n;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      dph = 1'b0; wleft = 0; stall_left = 0; resp_pend = 1'b0;
      hready_n = 1'b1; hresp_n = 1'b0;
    end else begin
      if (dph && stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) dph = 1'b0;
      end else if (dph && hready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {cap_addr, cap_write, cap_write ? hwdata : 32'd0}, 65'd0);
        end else begin
          check("xfer", {cap_addr, cap_write, cap_write ? hwdata : 32'd0}, exp_q.pop_front());
        end
        if (cap_write && cap_addr == BASE) mem = hwdata;
        dph = 1'b0;
        resp_pend = 1'b0;
      end
      if (htrans == 2'b10 && hready) begin
        cap_addr = haddr; cap_write = hwrite; dph = 1'b1; wleft = ws;
        resp_pend = err_arm; err_arm = 1'b0;
        if (stall_arm) begin stall_left = 300; stall_arm = 1'b0; end
      end
      hready_n = 1'b1;
      if (dph && stall_left > 0) hready_n = 1'b0;
      else if (dph && wleft > 0) begin hready_n = 1'b0; wleft--; end
      hresp_n = dph && resp_pend && hready_n;
    end
  end

  // Completion monitor: counts done pulses and their distance from the start of the code write.
  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      if (done) begin
        done_cnt++;
        last_lat = cyc - t_start;
        done_times.push_back(cyc);
      end
      if (htrans == 2'b10 && haddr == BASE && hwrite) t_start = cyc;
    end
  end

  task automatic expect_seq(input logic [4:0] c);
    exp_q.push_back({BASE, 1'b1, 27'd0, c});
`ifdef SSD_WR_READBACK_EN
    exp_q.push_back({BASE, 1'b0, 32'd0});
`endif
    exp_q.push_back({BASE + 32'h4, 1'b1, 32'h1});
    exp_done++;
  endtask

  task automatic push(input logic [4:0] c);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check("push_timeout", 65'(t), 65'd0);
    valid = 1'b1; cls = c;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || !ready || dph) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("idle_timeout", 65'(t), 65'd0);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  65'(ready), 65'd1);
    check("rst_busy",   65'(busy), 65'd0);
    check("rst_done",   65'(done), 65'd0);
    check("rst_err",    65'(err), 65'd0);
    check("rst_htrans", 65'(htrans), 65'd0);
    check("rst_haddr",  65'(haddr), 65'd0);
    check("rst_hwdata", 65'(hwdata), 65'd0);
    check("rst_hwrite", 65'(hwrite), 65'd0);
    check("rst_const",  65'({hsize, hburst, hprot, hmastlock}), 65'({3'b010, 3'b000, 4'b0011, 1'b0}));
    resetn = 1'b1;

    // Zero-wait single result
    ws = 0;
    expect_seq(5'd5);
    push(5'd5);
    wait_idle();
    check("zw_latency", 65'(last_lat), 65'(LAT0));
    check("zw_err", 65'(err), 65'd0);
    check("zw_done_cnt", 65'(done_cnt), 65'(exp_done));

    // One wait state, back-to-back results
    ws = 1;
    expect_seq(5'd3);
    expect_seq(5'd17);
    push(5'd3);
    push(5'd17);
    check("b2b_ready_low", 65'(ready), 65'd0);
    wait_idle();
    check("b2b_done_gap", 65'(done_times[done_times.size()-1] - done_times[done_times.size()-2]), 65'(LAT1));
    check("b2b_latency", 65'(last_lat), 65'(LAT1));
    check("b2b_done_cnt", 65'(done_cnt), 65'(exp_done));

    // Error response on the code write
    ws = 0;
    err_arm = 1'b1;
    exp_q.push_back({BASE, 1'b1, 32'd8});
    push(5'd8);
    wait_idle();
    check("hresp_err", 65'(err), 65'd1);
    repeat (5) @(negedge clk);
    check("hresp_sticky", 65'(err), 65'd1);
    check("hresp_no_done", 65'(done_cnt), 65'(exp_done));
    pulse_clr();
    check("err_cleared", 65'(err), 65'd0);
    expect_seq(5'd12);
    push(5'd12);
    wait_idle();
    check("after_err_ok", 65'(err), 65'd0);
    check("after_err_done", 65'(done_cnt), 65'(exp_done));

    // Stall timeout in the code-write data phase
    begin
      int bcnt = 0, t = 0;
      stall_arm = 1'b1;
      push(5'd9);
      repeat (100) @(negedge clk);
      check("stall_busy", 65'(busy), 65'd1);
      bcnt = 101;
      while (busy && t < 1000) begin @(negedge clk); bcnt++; t++; end
      n_checks++;
      if (bcnt < 250 || bcnt > 262) begin
        n_fail++;
        $display("FAIL stall_abort_window: busy cycles %0d expected 250..262", bcnt);
      end
      check("stall_err", 65'(err), 65'd1);
      check("stall_idle", 65'(busy), 65'd0);
      wait_idle();
      check("stall_no_done", 65'(done_cnt), 65'(exp_done));
      pulse_clr();
    end

    // Reset during the done-write address phase; pending result is lost
    begin
      int t = 0;
      exp_q.push_back({BASE, 1'b1, 32'd20});
`ifdef SSD_WR_READBACK_EN
      exp_q.push_back({BASE, 1'b0, 32'd0});
`endif
      push(5'd20);
      push(5'd21);
      while (!(htrans == 2'b10 && haddr == BASE + 32'h4) && t < 100) begin @(negedge clk); t++; end
      check("reach_a_done", 65'(t < 100), 65'd1);
      resetn = 1'b0;
      @(negedge clk);
      check("rst_mid_htrans", 65'(htrans), 65'd0);
      check("rst_mid_ready", 65'(ready), 65'd1);
      check("rst_mid_busy", 65'(busy), 65'd0);
      resetn = 1'b1;
      repeat (30) @(negedge clk);
      check("rst_mid_no_done", 65'(done_cnt), 65'(exp_done));
      check("rst_mid_no_xfer", 65'(exp_q.size()), 65'd0);
      exp_q.delete();
    end

`ifdef SSD_WR_READBACK_EN
    // Readback mismatch then match
    ws = 0;
    rb_force = 1'b1; rb_val = 32'd4;
    exp_q.push_back({BASE, 1'b1, 32'd6});
    exp_q.push_back({BASE, 1'b0, 32'd0});
    push(5'd6);
    wait_idle();
    check("rb_mismatch_err", 65'(err), 65'd1);
    check("rb_mismatch_no_done", 65'(done_cnt), 65'(exp_done));
    pulse_clr();
    rb_force = 1'b0;
    expect_seq(5'd6);
    push(5'd6);
    wait_idle();
    check("rb_match_err", 65'(err), 65'd0);
    check("rb_match_latency", 65'(last_lat), 65'd6);
`endif

    // Randomized results with random wait states and gaps
    for (int i = 0; i < 40; i++) begin
      logic [4:0] c;
      c = 5'($urandom_range(0, 31));
      ws = $urandom_range(0, 1);
      expect_seq(c);
      push(c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    check("rand_done_cnt", 65'(done_cnt), 65'(exp_done));
    check("rand_err", 65'(err), 65'd0);
    check("rand_drained", 65'(exp_q.size()), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ssd_result_writer.md
# ssd_result_writer

AHB-Lite initiator that delivers classifier results to the seven-segment display responder at `SSD_BASE_ADDR`. For each accepted 5-bit class code it performs two single writes:
- the class code to offset 0x0;
- 1 to offset 0x4 (the "done" strobe that makes the display latch the code).

A one-entry holding buffer decouples the classifier from bus stalls. Error and timeout detection is sticky, and an optional readback check is available.

## Interface
Parameters:
- `SSD_BASE_ADDR`, default 32'hC000_0000: base address of the display responder.
- `TIMEOUT_CYCLES`, default 255: maximum consecutive cycles with `ahb_m0_hready_i` = 0 in any one phase before the sequence aborts.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock (100 MHz).
- `resetn`  in  1  asynchronous active-low reset.
- `result_valid_i`  in  1  classifier result valid.
- `result_class_i`  in  5  class code (0–23 letters; other values are passed through unmodified).
- `result_ready_o`  out  1  holding buffer empty; handshake occurs when valid && ready.
- `busy_o`  out  1  high whenever the FSM is not IDLE.
- `done_o`  out  1  one-cycle pulse when a sequence completes successfully.
- `err_o`  out  1  sticky error flag; cleared by `err_clr_i` or reset.
- `err_clr_i`  in  1  clears `err_o`.
- `ahb_m0_haddr_o`  out  32  address.
- `ahb_m0_hwrite_o`  out  1  write enable.
- `ahb_m0_hsize_o`  out  3  constant 3'b010.
- `ahb_m0_hburst_o`  out  3  constant 3'b000.
- `ahb_m0_hprot_o`  out  4  constant 4'b0011.
- `ahb_m0_htrans_o`  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- `ahb_m0_hmastlock_o`  out  1  constant 0.
- `ahb_m0_hwdata_o`  out  32  write data, valid during the data phase.
- `ahb_m0_hrdata_i`  in  32  read data.
- `ahb_m0_hready_i`  in  1  transfer ready.
- `ahb_m0_hresp_i`  in  1  1 = ERROR.

## Operation
- **Holding buffer:** `pend_vld` and `pend_cls[4:0]`.
  - `result_ready_o` = !`pend_vld`.
  - The handshake loads the buffer.
  - The FSM in IDLE with `pend_vld` = 1 consumes the buffer by copying it to `cur_cls` and clearing `pend_vld`. It goes to A_DATA on the same edge.
  - A load and a consume never coincide, because ready is low while the buffer is full.
- **FSM states:**
  - IDLE
  - A_DATA, D_DATA: write `cur_cls` to base+0x0.
  - A_RB, D_RB: readback, only with the macro (see Configuration).
  - A_DONE, D_DONE: write 32'h1 to base+0x4.
- **Address phase (A_*):**
  - Drives NONSEQ, the address, and hwrite.
  - Advances to the matching D_* state on the first edge with hready = 1.
- **Data phase (D_*):**
  - Drives htrans = IDLE and haddr = 0. hwdata holds the data for write phases.
  - Completes on an edge with hready = 1.
  - If hresp = 1 at completion, or at any cycle where hresp = 1 while hready = 0, the FSM sets `err_o` and returns to IDLE. The done write is skipped.
- **Transitions:**
  - D_DATA goes to A_DONE (or A_RB with the macro).
  - D_DONE goes to IDLE and pulses `done_o`.
- **hwdata:** `{27'b0, cur_cls}` in D_DATA, 32'h1 in D_DONE, 0 otherwise.
- **Timeout:**
  - An 8-bit stall counter resets on every state change.
  - When the count reaches `TIMEOUT_CYCLES` with hready still 0, the FSM sets `err_o` and forces IDLE.
- **`err_o`:** `err_clr_i` has priority over a simultaneous new error, so `err_o` = 0. Errors never block new acceptances.
- **Reset values:**
  - All bus outputs 0, except the constant outputs (hsize, hburst, hprot, hmastlock) at their fixed values.
  - htrans = IDLE, `result_ready_o` = 1, `busy_o` = 0, `done_o` = 0, `err_o` = 0.
  - State IDLE, buffer empty.
- **Reset mid-sequence:** the transfer is abandoned immediately with no completion pulse, and the buffered result is lost.

## Timing
- All outputs are registered from FSM state. htrans is NONSEQ exactly in the cycles where state is A_*.
- **Zero-wait responder, accept at edge N:**
  - A_DATA in cycle N..N+1.
  - D_DATA in cycle N+1..N+2.
  - A_DONE in cycle N+2..N+3.
  - D_DONE in cycle N+3..N+4.
  - `done_o` high in cycle N+4..N+5.
  - Back-to-back results: the second sequence's A_DATA starts at N+4, so the gap between sequences is zero cycles.
- **Responder that inserts one wait state after each NONSEQ:** each D_* phase lengthens by 1 cycle, and `done_o` arrives at N+6.
- A new result can be accepted one cycle after the buffer is consumed, so the pipeline holds one active sequence and one pending result.

## Configuration
- `SSD_WR_READBACK_EN` defined:
  - After D_DATA, the FSM performs a read of base+0x0 (A_RB, then D_RB).
  - At D_RB completion it compares `hrdata[4:0]` with `cur_cls`.
  - On mismatch it sets `err_o` and skips the done write.
  - Adds 2 cycles per sequence on a zero-wait bus.
- Undefined: the RB states, the compare logic, and the `ahb_m0_hrdata_i` usage are compiled out, and `hrdata` is ignored.

## Test plan
- Zero-wait slave, push class 5 → NONSEQ write 0xC000_0000 data 5, then NONSEQ write 0xC000_0004 data 1; `done_o` at N+4; `err_o` = 0.
- Slave inserting one wait state, push 3 then 17 back-to-back → `result_ready_o` drops after the second push and the writes occur in order (3, 1, 17, 1); two `done_o` pulses 6 cycles apart.
- hresp = 1 on the first data phase for class 8 → no write to 0x4, `err_o` = 1 sticky; `err_clr_i` clears it; the next result completes normally.
- hready held low for 300 cycles in D_DATA → abort at stall count 255, `err_o` = 1, `busy_o` = 0.
- Assert resetn low during A_DONE → next cycle htrans = IDLE, `result_ready_o` = 1, no `done_o`.
- With `SSD_WR_READBACK_EN`, slave returns 4 for written 6 → `err_o` = 1 and no done write; returning 6 → done write issued and `done_o` at N+6.
